chunk_logic_engine: RTL and testbench

CHUNK_LOGIC_ENGINE -- requirements
Module: chunk_logic_engine

---
 rtl/chunk_logic_if.sv | 26 ++
 rtl/chunk_logic_engine.sv | 113 +++++++++++
 tb/tb_chunk_logic_engine.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chunk_logic_if.sv
// Handshake and data bundle for chunk_logic_engine.
// master = operand producer / result consumer, slave = the engine.
interface chunk_logic_if #(
  parameter int HI = 3,
  parameter int LO = 0
);
  logic          in_valid;
  logic          in_ready;
  logic [HI:LO]  a;
  logic [HI:LO]  b;
  logic          out_valid;
  logic          out_ready;
  logic [HI:LO]  y;
  logic          busy;
  logic [7:0]    done_count;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, busy, done_count
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, busy, done_count
  );
endinterface

// File: rtl/chunk_logic_engine.sv
// Chunk-serial logic engine: latches an operand pair, then computes one
// SPAN-bit chunk of the result per cycle (bitwise or logical AND) and
// holds the result until the consumer takes it.
module chunk_logic_engine #(
  parameter int         HI    = 3,
  parameter int         LO    = 0,
  parameter int         SPAN  = 1,
  parameter logic [2:0] SWAPS = 3'b000,
  parameter int         MODE  = 0
) (
  input logic          clk,
  input logic          rst,
  chunk_logic_if.slave bus
);

  localparam int WIDTH  = HI - LO + 1;
  localparam int NCHUNK = WIDTH / SPAN;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [HI:LO]  a_q;
  logic [HI:LO]  b_q;
  logic [HI:LO]  res_q;
  logic [HI:LO]  res_next;
  logic [KW-1:0] k_q;
  logic [7:0]    count_q;
  logic          last_chunk;

  // Mirror a vector about its own index range: bit i takes bit HI+LO-i.
  function automatic logic [HI:LO] reverse(input logic [HI:LO] v);
    logic [HI:LO] r;
    for (int i = LO; i <= HI; i++) begin
      r[i] = v[HI + LO - i];
    end
    return r;
  endfunction

  assign last_chunk = (k_q == KW'(NCHUNK - 1));

  // Working result with the current chunk k written; tail bits never touched.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    res_next = res_q;
    for (int j = 0; j < NCHUNK; j++) begin
      if (k_q == KW'(j)) begin
        if (MODE == 0) begin
          res_next[LO + j*SPAN +: SPAN] = a_q[LO + j*SPAN +: SPAN] & b_q[LO + j*SPAN +: SPAN];
        end else begin
          res_next[LO + j*SPAN +: SPAN] = '0;
          res_next[LO + j*SPAN]         = (|a_q[LO + j*SPAN +: SPAN]) && (|b_q[LO + j*SPAN +: SPAN]);
        end
      end
    end
  end

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_next = RUN;
      RUN:  if (last_chunk) state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, operand, result, chunk-counter and completion-counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      count_q <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= SWAPS[0] ? reverse(bus.a) : bus.a;
            b_q   <= SWAPS[1] ? reverse(bus.b) : bus.b;
            res_q <= '0;
            k_q   <= '0;
          end
        end
        RUN: begin
          res_q <= res_next;
          k_q   <= k_q + KW'(1);
        end
        DONE: begin
          if (bus.out_ready) count_q <= count_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.busy       = (state == RUN);
  assign bus.done_count = count_q;
  assign bus.y          = (state != DONE) ? '0 : (SWAPS[2] ? reverse(res_q) : res_q);

endmodule

// File: tb/tb_chunk_logic_engine.sv
// Bench for chunk_logic_engine: directed vectors on five 4-bit configurations
// plus an exhaustive sweep of small shapes against a reference function.
module tb_chunk_logic_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int sweep_done = 0;

  localparam int N_SWEEP = 160;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: work in normalised bit order (bit i = position LO+i).
  function automatic logic [31:0] ref_y(input int w, input int span, input logic [2:0] swaps,
                                        input int mode, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ra, rb, r, o;
    logic any_a, any_b;
    int n, p;
    n = w / span;
    ra = '0; rb = '0; r = '0; o = '0;
    for (int i = 0; i < w; i++) begin
      ra[i] = swaps[0] ? a[w-1-i] : a[i];
      rb[i] = swaps[1] ? b[w-1-i] : b[i];
    end
    for (int k = 0; k < n; k++) begin
      any_a = 1'b0;
      any_b = 1'b0;
      for (int j = 0; j < span; j++) begin
        p = k*span + j;
        if (mode == 0) r[p] = ra[p] & rb[p];
        any_a = any_a | ra[p];
        any_b = any_b | rb[p];
      end
      if (mode == 1) r[k*span] = any_a & any_b;
    end
    for (int i = 0; i < w; i++) o[i] = swaps[2] ? r[w-1-i] : r[i];
    return o;
  endfunction

  // ---------------- directed 4-bit DUTs ----------------
  localparam int NM = 5;
  localparam int         M_SPAN [NM] = '{1, 2, 3, 1, 1};
  localparam logic [2:0] M_SW   [NM] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b100};
  localparam int         M_MODE [NM] = '{0, 1, 0, 0, 0};

  logic       m_rst       [NM];
  logic       m_in_valid  [NM];
  logic [3:0] m_a         [NM];
  logic [3:0] m_b         [NM];
  logic       m_out_ready [NM];
  logic       m_in_ready  [NM];
  logic       m_out_valid [NM];
  logic       m_busy      [NM];
  logic [3:0] m_y         [NM];
  logic [7:0] m_cnt       [NM];

  for (genvar g = 0; g < NM; g++) begin : g_main
    chunk_logic_if #(.HI(3), .LO(0)) bus ();
    assign bus.in_valid  = m_in_valid[g];
    assign bus.a         = m_a[g];
    assign bus.b         = m_b[g];
    assign bus.out_ready = m_out_ready[g];
    assign m_in_ready[g]  = bus.in_ready;
    assign m_out_valid[g] = bus.out_valid;
    assign m_busy[g]      = bus.busy;
    assign m_y[g]         = bus.y;
    assign m_cnt[g]       = bus.done_count;
    chunk_logic_engine #(
      .HI(3), .LO(0), .SPAN(M_SPAN[g]), .SWAPS(M_SW[g]), .MODE(M_MODE[g])
    ) dut (
      .clk(clk),
      .rst(m_rst[g]),
      .bus(bus.slave)
    );
  end

  // ---------------- exhaustive small-shape sweep ----------------
  for (genvar hi = 0; hi <= 2; hi++) begin : g_hi
    for (genvar lo = 0; lo <= hi; lo++) begin : g_lo
      for (genvar sp = 1; sp <= hi - lo + 1; sp++) begin : g_sp
        for (genvar sw = 0; sw < 8; sw++) begin : g_sw
          for (genvar md = 0; md < 2; md++) begin : g_md
            localparam int W = hi - lo + 1;
            logic         s_rst;
            logic         s_iv;
            logic         s_ordy;
            logic [hi:lo] s_a;
            logic [hi:lo] s_b;
            chunk_logic_if #(.HI(hi), .LO(lo)) bus ();
            assign bus.in_valid  = s_iv;
            assign bus.a         = s_a;
            assign bus.b         = s_b;
            assign bus.out_ready = s_ordy;
            chunk_logic_engine #(
              .HI(hi), .LO(lo), .SPAN(sp), .SWAPS(3'(sw)), .MODE(md)
            ) dut (
              .clk(clk),
              .rst(s_rst),
              .bus(bus.slave)
            );
            initial begin
              int lat;
              s_rst = 1'b1; s_iv = 1'b0; s_ordy = 1'b0; s_a = '0; s_b = '0;
              @(posedge clk); #1;
              s_rst = 1'b0;
              for (int av = 0; av < (1 << W); av++) begin
                for (int bv = 0; bv < (1 << W); bv++) begin
                  s_a = W'(av); s_b = W'(bv); s_iv = 1'b1;
                  @(posedge clk); #1;
                  s_iv = 1'b0;
                  lat = 0;
                  while (!bus.out_valid && lat < 10) begin
                    @(posedge clk); #1;
                    lat++;
                  end
                  check($sformatf("sweep lat hi%0d lo%0d sp%0d", hi, lo, sp), lat, W / sp);
                  check($sformatf("sweep y hi%0d lo%0d sp%0d sw%0d md%0d a%0h b%0h", hi, lo, sp, sw, md, av, bv),
                        32'(bus.y), ref_y(W, sp, 3'(sw), md, av, bv));
                  s_ordy = 1'b1;
                  @(posedge clk); #1;
                  s_ordy = 1'b0;
                end
              end
              sweep_done++;
            end
          end
        end
      end
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic run_op(input int i, input logic [3:0] a, input logic [3:0] b,
                        output int lat, output logic [3:0] y);
    check($sformatf("in_ready before op dut%0d", i), m_in_ready[i], 1'b1);
    m_a[i] = a; m_b[i] = b; m_in_valid[i] = 1'b1;
    @(posedge clk); #1;
    m_in_valid[i] = 1'b0; m_a[i] = ~a; m_b[i] = ~b;
    check($sformatf("busy in RUN dut%0d", i), m_busy[i], 1'b1);
    lat = 0;
    while (!m_out_valid[i] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    y = m_y[i];
  endtask

  task automatic take(input int i);
    m_out_ready[i] = 1'b1;
    @(posedge clk); #1;
    m_out_ready[i] = 1'b0;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lat, seen, cyc;
    logic [3:0] y;

    vecs[0] = '{4'b0110, 4'b1100, 4'b0100};
    vecs[1] = '{4'b1111, 4'b1111, 4'b1111};
    vecs[2] = '{4'b0000, 4'b1111, 4'b0000};
    vecs[3] = '{4'b1010, 4'b0110, 4'b0010};
    vecs[4] = '{4'b1011, 4'b1101, 4'b1001};

    for (int i = 0; i < NM; i++) begin
      m_rst[i] = 1'b1; m_in_valid[i] = 1'b0; m_out_ready[i] = 1'b0;
      m_a[i] = '0; m_b[i] = '0;
    end
    @(posedge clk); #1;
    for (int i = 0; i < NM; i++) m_rst[i] = 1'b0;

    // Reset state
    check("reset in_ready",   m_in_ready[0], 1'b1);
    check("reset out_valid",  m_out_valid[0], 1'b0);
    check("reset busy",       m_busy[0], 1'b0);
    check("reset y",          m_y[0], 4'b0000);
    check("reset done_count", m_cnt[0], 8'd0);

    // Table-driven: SPAN=1, MODE=0, no swaps
    for (int v = 0; v < 5; v++) begin
      run_op(0, vecs[v].a, vecs[v].b, lat, y);
      check($sformatf("vec%0d latency", v), lat, 4);
      check($sformatf("vec%0d y", v), y, vecs[v].y);
      take(0);
      check($sformatf("vec%0d done_count", v), m_cnt[0], 8'(v + 1));
      check($sformatf("vec%0d y after take", v), m_y[0], 4'b0000);
    end

    // SPAN=2, MODE=1
    run_op(1, 4'b0110, 4'b1100, lat, y);
    check("span2 logical latency", lat, 2);
    check("span2 logical y", y, 4'b0100);
    take(1);
    run_op(1, 4'b0001, 4'b0010, lat, y);
    check("span2 logical y2", y, 4'b0001);
    take(1);
    check("span2 done_count", m_cnt[1], 8'd2);

    // SPAN=3, MODE=0: partial tail reads 0
    run_op(2, 4'b1111, 4'b1111, lat, y);
    check("span3 latency", lat, 1);
    check("span3 tail y", y, 4'b0111);
    take(2);

    // Operand / result reversal
    run_op(3, 4'b0011, 4'b1100, lat, y);
    check("swap a y", y, 4'b1100);
    take(3);
    run_op(4, 4'b1100, 4'b1100, lat, y);
    check("swap y y", y, 4'b0011);
    take(4);

    // Backpressure: hold out_ready low for 5 cycles, offer junk on inputs
    run_op(0, 4'b1111, 4'b0101, lat, y);
    check("bp y", y, 4'b0101);
    for (int c = 0; c < 5; c++) begin
      m_in_valid[0] = 1'b1; m_a[0] = 4'b0000; m_b[0] = 4'b0000;
      @(posedge clk); #1;
      check($sformatf("bp%0d out_valid", c), m_out_valid[0], 1'b1);
      check($sformatf("bp%0d y", c), m_y[0], 4'b0101);
      check($sformatf("bp%0d in_ready", c), m_in_ready[0], 1'b0);
      check($sformatf("bp%0d done_count", c), m_cnt[0], 8'd5);
    end
    m_in_valid[0] = 1'b0;
    take(0);
    check("bp release out_valid", m_out_valid[0], 1'b0);
    check("bp release in_ready", m_in_ready[0], 1'b1);
    check("bp release done_count", m_cnt[0], 8'd6);

    // Reset in the 2nd RUN cycle, colliding with in_valid and out_ready
    m_a[0] = 4'b1111; m_b[0] = 4'b1111; m_in_valid[0] = 1'b1;
    @(posedge clk); #1;
    m_in_valid[0] = 1'b0;
    @(posedge clk); #1;
    check("mid-run busy", m_busy[0], 1'b1);
    m_rst[0] = 1'b1; m_in_valid[0] = 1'b1; m_out_ready[0] = 1'b1;
    @(posedge clk); #1;
    m_rst[0] = 1'b0; m_in_valid[0] = 1'b0; m_out_ready[0] = 1'b0;
    check("rst in_ready", m_in_ready[0], 1'b1);
    check("rst out_valid", m_out_valid[0], 1'b0);
    check("rst busy", m_busy[0], 1'b0);
    check("rst y", m_y[0], 4'b0000);
    check("rst done_count", m_cnt[0], 8'd0);
    repeat (6) @(posedge clk);
    #1;
    check("rst discarded op", m_out_valid[0], 1'b0);

    // 256 back-to-back transfers wrap done_count
    m_a[0] = 4'b1010; m_b[0] = 4'b1010;
    m_in_valid[0] = 1'b1; m_out_ready[0] = 1'b1;
    seen = 0; cyc = 0;
    while (seen < 256 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (m_out_valid[0]) seen++;
    end
    check("wrap transfers seen", seen, 256);
    check("wrap count before last take", m_cnt[0], 8'd255);
    m_in_valid[0] = 1'b0;
    @(posedge clk); #1;
    m_out_ready[0] = 1'b0;
    check("wrap count", m_cnt[0], 8'd0);
    check("wrap in_ready", m_in_ready[0], 1'b1);

    // Wait for the sweep to finish
    cyc = 0;
    while (sweep_done < N_SWEEP && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("sweep instances complete", sweep_done, N_SWEEP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
